// File: rtl/video_pll_supervisor.sv
// Video PLL lock supervisor and staggered per-domain reset sequencer in the refclk domain; VIDEO_PLL_SUPERVISOR_LOL_COUNT_EN adds lol_count.
// Latency: pll_locked reaches decisions after a 2-flop synchroniser; every output is registered, so it lags its cause by one cycle.
// Backpressure: none; restart is a single-cycle request and always wins over the other transitions.
module video_pll_supervisor #(
  parameter int NUM_CLOCKS         = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 50000,
  parameter int STAGGER_CYCLES     = 8,
  parameter int MAX_RETRIES        = 3,
  localparam int RCW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  restart,
  input  logic [NUM_CLOCKS-1:0] channel_enable,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] domain_rst_n,
  output logic                  all_ready,
  output logic                  fault,
  output logic [RCW-1:0]        retry_count
`ifdef VIDEO_PLL_SUPERVISOR_LOL_COUNT_EN
  ,
  output logic [15:0]           lol_count
`endif
);

  localparam int C1   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int C2   = (TIMEOUT_CYCLES > STAGGER_CYCLES) ? TIMEOUT_CYCLES : STAGGER_CYCLES;
  localparam int CMAX = (C1 > C2) ? C1 : C2;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

  localparam logic [CW-1:0]  RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  STG_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_CLOCKS - 1);
  localparam logic [RCW-1:0] RC_MAX    = RCW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [RCW-1:0]        rc_nxt;
  logic [NUM_CLOCKS-1:0] en_q, en_nxt, dom_nxt;
  logic                  lk_meta, lk;
  logic                  pll_rst_nxt, all_ready_nxt, fault_nxt;
`ifdef VIDEO_PLL_SUPERVISOR_LOL_COUNT_EN
  logic                  lol_evt;
`endif

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RESET_PLL;
      cnt          <= '0;
      idx          <= '0;
      en_q         <= '0;
      retry_count  <= '0;
      pll_rst      <= 1'b1;
      domain_rst_n <= '0;
      all_ready    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      en_q         <= en_nxt;
      retry_count  <= rc_nxt;
      pll_rst      <= pll_rst_nxt;
      domain_rst_n <= dom_nxt;
      all_ready    <= all_ready_nxt;
      fault        <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rc_nxt    = retry_count;
    en_nxt    = en_q;
`ifdef VIDEO_PLL_SUPERVISOR_LOL_COUNT_EN
    lol_evt   = 1'b0;
`endif
    if (restart) begin
      state_nxt = RESET_PLL;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      rc_nxt    = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            cnt_nxt = '0;
            if (retry_count < RC_MAX) begin
              rc_nxt    = retry_count + 1'b1;
              state_nxt = RESET_PLL;
            end else begin
              state_nxt = FAULT;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!lk) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STB_LAST) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            en_nxt    = channel_enable;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RELEASE: begin
          // The last channel goes to RUN on its release cycle; no trailing stagger.
          if (!lk) begin
            state_nxt = RESET_PLL;
            cnt_nxt   = '0;
            idx_nxt   = '0;
`ifdef VIDEO_PLL_SUPERVISOR_LOL_COUNT_EN
            lol_evt   = 1'b1;
`endif
          end else if (idx == IDX_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rc_nxt    = '0;
          end else if (!en_q[idx] || cnt == STG_LAST) begin
            idx_nxt = idx + 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state_nxt = RESET_PLL;
            cnt_nxt   = '0;
`ifdef VIDEO_PLL_SUPERVISOR_LOL_COUNT_EN
            lol_evt   = 1'b1;
`endif
          end
        end
        FAULT: state_nxt = FAULT;
        default: begin
          state_nxt = RESET_PLL;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pll_rst_nxt   = (state_nxt == RESET_PLL) || (state_nxt == FAULT);
    all_ready_nxt = (state_nxt == RUN);
    fault_nxt     = (state_nxt == FAULT);
    dom_nxt       = '0;
    if (state_nxt == RELEASE || state_nxt == RUN) begin
      dom_nxt = domain_rst_n;
      // In RUN an enable can only withdraw a domain; new enables wait for the next RELEASE.
      if (state == RUN)
        dom_nxt = domain_rst_n & channel_enable;
      else if (state == RELEASE && en_q[idx] && cnt == '0)
        dom_nxt[idx] = 1'b1;
    end
  end

`ifdef VIDEO_PLL_SUPERVISOR_LOL_COUNT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      lol_count <= '0;
    else if (lol_evt && lol_count != 16'hFFFF)
      lol_count <= lol_count + 16'd1;
  end
`endif

endmodule
